// File: rtl/pim_dma_target.sv
// PIM window bus responder: buffers weight/activation words, runs a packed int8 dot product
// over N word pairs on start, and queues 32-bit results for readback.
module pim_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_wdata,
    output logic [W-1:0]             o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Callers gate push with !full and pop with !empty, so both may fire together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_wdata;
    end

    assign o_rdata = mem[rd_ptr];
    assign o_full  = (count == (AW+1)'(DEPTH));
    assign o_empty = (count == '0);
    assign o_count = count;
endmodule

module pim_dma_target #(
    parameter logic [31:0] PIM_CTRL         = 32'h2000_0010,
    parameter logic [31:0] PIM_R            = 32'h2000_0020,
    parameter logic [31:0] PIM_W_WEIGHT     = 32'h2000_0040,
    parameter logic [31:0] PIM_W_ACTIVATION = 32'h2000_0080,
    parameter int          FIFO_DEPTH       = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_addr,
    input  logic        i_write,
    input  logic        i_read,
    input  logic [3:0]  i_size,
    input  logic [31:0] i_din,
    output logic [31:0] o_dout,
    output logic        o_busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic signed [31:0] acc;
    logic [7:0]         cnt;
    logic               ovf, sz_err;

    logic [31:0] w_head, a_head, r_head;
    logic        w_full, w_empty, a_full, a_empty, r_full, r_empty;
    logic [CW-1:0] w_count, a_count, r_count;

    logic hit_ctrl, hit_r, hit_w, hit_a, hit_pim, wr_ok;
    logic w_push, a_push, w_drop, a_drop, compute_pop, r_pop, r_push;
    logic start, clear, sz_bad;

    function automatic logic signed [31:0] dot4(input logic [31:0] w, input logic [31:0] a);
        logic signed [31:0] sum;
        logic signed [7:0]  w_s, a_s;
        logic signed [15:0] prod;
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            w_s  = w[8*k +: 8];
            a_s  = a[8*k +: 8];
            prod = 16'(w_s) * 16'(a_s);
            sum  = sum + 32'(prod);
        end
        return sum;
    endfunction

    assign hit_ctrl = (i_addr == PIM_CTRL);
    assign hit_r    = (i_addr == PIM_R);
    assign hit_w    = (i_addr == PIM_W_WEIGHT);
    assign hit_a    = (i_addr == PIM_W_ACTIVATION);
    assign hit_pim  = hit_ctrl | hit_r | hit_w | hit_a;
    assign wr_ok    = i_write && (i_size == 4'hF);

    // Full is judged on the pre-pop count, so a push to a full FIFO drops even if compute pops.
    assign w_push      = wr_ok && hit_w && !w_full;
    assign w_drop      = wr_ok && hit_w && w_full;
    assign a_push      = wr_ok && hit_a && !a_full;
    assign a_drop      = wr_ok && hit_a && a_full;
    assign compute_pop = (state == RUN) && !w_empty && !a_empty;
    assign r_pop       = i_read && hit_r && !r_empty;
    assign r_push      = (state == DONE) && !r_full;
    assign start       = wr_ok && hit_ctrl && i_din[0] && (state == IDLE);
    assign clear       = wr_ok && hit_ctrl && i_din[31];
    assign sz_bad      = i_write && (i_size != 4'hF) && hit_pim;

    pim_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_wgt (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(w_push), .i_pop(compute_pop), .i_wdata(i_din),
        .o_rdata(w_head), .o_full(w_full), .o_empty(w_empty), .o_count(w_count));
    pim_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_act (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(a_push), .i_pop(compute_pop), .i_wdata(i_din),
        .o_rdata(a_head), .o_full(a_full), .o_empty(a_empty), .o_count(a_count));
    pim_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_res (
        .i_clk(i_clk), .i_rst(i_rst), .i_push(r_push), .i_pop(r_pop), .i_wdata(acc),
        .o_rdata(r_head), .o_full(r_full), .o_empty(r_empty), .o_count(r_count));

    always_comb begin
        state_nxt = state;
        o_busy    = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = (i_din[11:4] == 8'd0) ? DONE : RUN;
            RUN:  if (compute_pop && cnt == 8'd1) state_nxt = DONE;
            DONE: if (!r_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            sz_err <= 1'b0;
            o_dout <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt <= i_din[11:4];
                acc <= '0;
            end else if (compute_pop) begin
                acc <= acc + dot4(w_head, a_head);
                cnt <= cnt - 8'd1;
            end
            if (clear)                ovf <= 1'b0;
            else if (w_drop || a_drop) ovf <= 1'b1;
            if (clear)                sz_err <= 1'b0;
            else if (sz_bad)          sz_err <= 1'b1;
            if (i_read && hit_r)
                o_dout <= r_empty ? 32'd0 : r_head;
            else if (i_read && hit_ctrl)
                o_dout <= {(state != IDLE), ovf, sz_err, 5'b0,
                           8'(r_count), 8'(a_count), 8'(w_count)};
            else
                o_dout <= '0;
        end
    end

    wire unused_din = &{1'b0, i_din[30:12], i_din[3:1]};
endmodule

// File: tb/tb_pim_dma_target.sv
// Directed bench for pim_dma_target: read data is checked through an expected-value queue.
module tb_pim_dma_target;
    localparam logic [31:0] A_CTRL = 32'h2000_0010;
    localparam logic [31:0] A_R    = 32'h2000_0020;
    localparam logic [31:0] A_W    = 32'h2000_0040;
    localparam logic [31:0] A_A    = 32'h2000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  size = 4'hF;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        busy;

    int passed = 0;
    int total  = 0;
    logic pend = 1'b0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    pim_dma_target dut (
        .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_write(wr), .i_read(rd),
        .i_size(size), .i_din(din), .o_dout(dout), .o_busy(busy));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [31:0] st(input bit b, input bit o, input bit s,
                                       input int res, input int act, input int wgt);
        return {b, o, s, 5'b0, 8'(res), 8'(act), 8'(wgt)};
    endfunction

    always @(posedge clk) pend <= rd;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                total++;
                $error("FAIL sb_underflow: got %h expected none", dout);
            end else begin
                chk(tag_q.pop_front(), dout, exp_q.pop_front());
            end
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        addr = a; din = d; size = s; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; size = 4'hF;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] expv, input string tag);
        addr = a; rd = 1'b1;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int cyc;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", {31'b0, busy}, 32'd0);
        bus_rd(A_CTRL, 32'd0, "rst_ctrl");
        @(negedge clk);
        chk("dout_no_read", dout, 32'd0);
        bus_rd(32'h2000_0000, 32'd0, "unmapped");

        // Single pair, positive result
        bus_wr(A_W, 32'h0102_0304);
        bus_wr(A_A, 32'h0101_0101);
        bus_rd(A_CTRL, st(0, 0, 0, 0, 1, 1), "ctrl_loaded");
        bus_wr(A_CTRL, 32'h0000_0011);
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        wait_idle(50, cyc);
        chk("busy_cycles_ok", {31'b0, (cyc >= 2 && cyc <= 3)}, 32'd1);
        bus_rd(A_CTRL, st(0, 0, 0, 1, 0, 0), "ctrl_res1");
        bus_rd(A_R, 32'h0000_000A, "res_pos");

        // Negative lanes
        bus_wr(A_W, 32'hFFFF_FFFF);
        bus_wr(A_A, 32'h0202_0202);
        bus_wr(A_CTRL, 32'h0000_0011);
        wait_idle(50, cyc);
        bus_rd(A_R, 32'hFFFF_FFF8, "res_neg");
        bus_rd(A_R, 32'd0, "res_empty");

        // Stall with too few pairs, then complete
        bus_wr(A_W, 32'h0101_0101);
        bus_wr(A_A, 32'h0101_0101);
        bus_wr(A_CTRL, 32'h0000_0031);
        repeat (10) @(negedge clk);
        chk("stall_busy", {31'b0, busy}, 32'd1);
        bus_rd(A_CTRL, st(1, 0, 0, 0, 0, 0), "ctrl_stall");
        bus_wr(A_W, 32'h0202_0202);
        bus_wr(A_A, 32'h0303_0303);
        bus_wr(A_W, 32'h7F7F_7F7F);
        bus_wr(A_A, 32'h8080_8080);
        wait_idle(50, cyc);
        bus_rd(A_CTRL, st(0, 0, 0, 1, 0, 0), "ctrl_one_res");
        bus_rd(A_R, 32'hFFFF_021C, "res_n3");

        // Overflow, size error, clear
        for (int k = 0; k < 17; k++) bus_wr(A_W, 32'(k));
        bus_rd(A_CTRL, st(0, 1, 0, 0, 0, 16), "ctrl_ovf");
        bus_wr(A_CTRL, 32'h0000_0011, 4'h1);
        chk("sz_no_start", {31'b0, busy}, 32'd0);
        bus_rd(A_CTRL, st(0, 1, 1, 0, 0, 16), "ctrl_szerr");
        bus_wr(A_CTRL, 32'h8000_0000);
        bus_rd(A_CTRL, st(0, 0, 0, 0, 0, 16), "ctrl_clear");

        // N=0 produces a zero result one cycle after start
        bus_wr(A_CTRL, 32'h0000_0001);
        chk("n0_busy", {31'b0, busy}, 32'd1);
        bus_rd(A_CTRL, st(1, 0, 0, 0, 0, 16), "ctrl_n0_done");
        chk("n0_idle", {31'b0, busy}, 32'd0);
        bus_rd(A_CTRL, st(0, 0, 0, 1, 0, 16), "ctrl_n0_res");
        bus_rd(A_R, 32'd0, "res_n0");

        // Reset mid-run
        bus_wr(A_A, 32'h0101_0101);
        bus_wr(A_CTRL, 32'h0000_0041);
        repeat (3) @(negedge clk);
        chk("run_busy", {31'b0, busy}, 32'd1);
        bus_rd(A_CTRL, st(1, 0, 0, 0, 0, 15), "ctrl_run");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        bus_rd(A_CTRL, 32'd0, "ctrl_after_rst");
        bus_rd(A_R, 32'd0, "res_after_rst");

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
